// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: state encodings and port IDs shared by the RAM arbiter files
package mem_arbiter_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;
  localparam logic P_CPU  = 1'b0;
  localparam logic P_HOST = 1'b1;
endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way picker, round-robin or fixed priority on a tie
module rr_pick2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       prio_mode,
  output logic       winner
);
  always_comb begin
    winner = req == 2'b01 ? P_CPU :
             req == 2'b10 ? P_HOST :
             prio_mode    ? P_CPU : ~last;
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single-port registered-output RAM between a CPU port and a host port
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 8,
  parameter int PRIO_MODE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_w_mem,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);
  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic              win_q;
  logic              last_q;
  logic              win;
  rr_pick2 u_pick (
    .req      ({req1, req0}),
    .last     (last_q),
    .prio_mode(PRIO_MODE != 0),
    .winner   (win)
  );
  // last_q resets to the host so the CPU takes the first tie
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      win_q   <= P_CPU;
      last_q  <= P_HOST;
    end else begin
      case (state)
        ST_IDLE: if (req0 || req1) begin
          state   <= ST_ACCESS;
          win_q   <= win;
          last_q  <= win;
          we_q    <= win ? we1 : we0;
          addr_q  <= win ? addr1 : addr0;
          wdata_q <= win ? wdata1 : wdata0;
        end
        ST_ACCESS: state <= we_q ? ST_IDLE : ST_RESP;
        default:   state <= ST_IDLE;
      endcase
    end
  end
  // outputs decode registered state only, so an async reset silences them at once
  always_comb begin
    gnt0      = state == ST_ACCESS && win_q == P_CPU;
    gnt1      = state == ST_ACCESS && win_q == P_HOST;
    rvalid0   = state == ST_RESP && win_q == P_CPU;
    rvalid1   = state == ST_RESP && win_q == P_HOST;
    busy      = state != ST_IDLE;
    ram_w_mem = state == ST_ACCESS && we_q;
    ram_addr  = addr_q;
    ram_din   = wdata_q;
    rdata     = state == ST_RESP ? ram_dout : '0;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter in round-robin and fixed-priority builds
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  logic       req[2], we[2], reqb[2], web[2];
  logic [3:0] addr[2], addrb[2];
  logic [7:0] wdata[2], wdatab[2];
  logic       g0, g1, rv0, rv1, busy, mw;
  logic       gb0, gb1, rvb0, rvb1, busyb, mwb;
  logic [3:0] ra, rab;
  logic [7:0] rd, din, dout, rdb, dinb, doutb;
  logic [7:0] mem0[16], mem1[16];
  int n_cmp = 0, n_err = 0, cyc = 0, mw_cnt = 0;
  int gcyc0 = 0, gcyc1 = 0, last_g0b = 0, g1_gap = -1;
  int a0, e0, a1, e1;
  int gq0[$], rq0[$], gq1[$], rq1[$];

  mem_arbiter #(.ADDR_W(4), .DATA_W(8), .PRIO_MODE(0)) dut_rr (
    .clk(clk), .reset(reset),
    .req0(req[0]), .req1(req[1]), .we0(we[0]), .we1(we[1]),
    .addr0(addr[0]), .addr1(addr[1]), .wdata0(wdata[0]), .wdata1(wdata[1]),
    .gnt0(g0), .gnt1(g1), .rvalid0(rv0), .rvalid1(rv1), .rdata(rd), .busy(busy),
    .ram_addr(ra), .ram_w_mem(mw), .ram_din(din), .ram_dout(dout)
  );
  mem_arbiter #(.ADDR_W(4), .DATA_W(8), .PRIO_MODE(1)) dut_fp (
    .clk(clk), .reset(reset),
    .req0(reqb[0]), .req1(reqb[1]), .we0(web[0]), .we1(web[1]),
    .addr0(addrb[0]), .addr1(addrb[1]), .wdata0(wdatab[0]), .wdata1(wdatab[1]),
    .gnt0(gb0), .gnt1(gb1), .rvalid0(rvb0), .rvalid1(rvb1), .rdata(rdb), .busy(busyb),
    .ram_addr(rab), .ram_w_mem(mwb), .ram_din(dinb), .ram_dout(doutb)
  );

  // RAM models: synchronous write, registered read output
  always @(posedge clk) begin
    if (mw) mem0[ra] <= din;
    dout <= mem0[ra];
    if (mwb) mem1[rab] <= dinb;
    doutb <= mem1[rab];
  end
  always @(posedge clk) cyc++;

  function automatic int enc_g(int p, int w, int a, int d);
    return p + 2 * w + 4 * a + 64 * (w != 0 ? d : 0);
  endfunction
  task automatic exp_w(input int d, input int p, input int a, input int dt);
    if (d == 0) gq0.push_back(enc_g(p, 1, a, dt)); else gq1.push_back(enc_g(p, 1, a, dt));
  endtask
  // a read expects its data exactly one cycle after its grant
  task automatic exp_r(input int d, input int p, input int a, input int dt);
    if (d == 0) begin
      gq0.push_back(enc_g(p, 0, a, 0));
      rq0.push_back(512 + p * 256 + dt);
    end else begin
      gq1.push_back(enc_g(p, 0, a, 0));
      rq1.push_back(512 + p * 256 + dt);
    end
  endtask
  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mw) mw_cnt++;
    if (g0 || g1) begin
      n_cmp++;
      gcyc0 = cyc;
      a0 = enc_g(int'(g1), int'(mw), int'(ra), int'(din));
      if (gq0.size() == 0 || (g0 && g1)) begin
        n_err++;
        $display("FAIL grant_rr: got %0h expected none", a0);
      end else begin
        e0 = gq0.pop_front();
        if (a0 != e0) begin n_err++; $display("FAIL grant_rr: got %0h expected %0h", a0, e0); end
      end
    end
    if (rv0 || rv1) begin
      n_cmp++;
      a0 = 512 * (cyc - gcyc0) + 256 * int'(rv1) + int'(rd);
      if (rq0.size() == 0 || (rv0 && rv1)) begin
        n_err++;
        $display("FAIL rvalid_rr: got %0h expected none", a0);
      end else begin
        e0 = rq0.pop_front();
        if (a0 != e0) begin n_err++; $display("FAIL rvalid_rr: got %0h expected %0h", a0, e0); end
      end
    end
  end
  always @(negedge clk) begin
    if (gb0) last_g0b = cyc;
    if (gb1 && g1_gap < 0) g1_gap = cyc - last_g0b;
    if (gb0 || gb1) begin
      n_cmp++;
      gcyc1 = cyc;
      a1 = enc_g(int'(gb1), int'(mwb), int'(rab), int'(dinb));
      if (gq1.size() == 0 || (gb0 && gb1)) begin
        n_err++;
        $display("FAIL grant_fp: got %0h expected none", a1);
      end else begin
        e1 = gq1.pop_front();
        if (a1 != e1) begin n_err++; $display("FAIL grant_fp: got %0h expected %0h", a1, e1); end
      end
    end
    if (rvb0 || rvb1) begin
      n_cmp++;
      a1 = 512 * (cyc - gcyc1) + 256 * int'(rvb1) + int'(rdb);
      if (rq1.size() == 0 || (rvb0 && rvb1)) begin
        n_err++;
        $display("FAIL rvalid_fp: got %0h expected none", a1);
      end else begin
        e1 = rq1.pop_front();
        if (a1 != e1) begin n_err++; $display("FAIL rvalid_fp: got %0h expected %0h", a1, e1); end
      end
    end
  end

  // holds req until the grant is seen, then drops it at the edge ending the grant cycle
  task automatic issue(input int d, input int p, input bit w, input logic [3:0] a, input logic [7:0] dt);
    bit got = 1'b0;
    if (d == 0) begin req[p] = 1'b1; we[p] = w; addr[p] = a; wdata[p] = dt; end
    else begin reqb[p] = 1'b1; web[p] = w; addrb[p] = a; wdatab[p] = dt; end
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = d == 0 ? (p == 0 ? g0 : g1) : (p == 0 ? gb0 : gb1);
    end
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout: dut%0d port%0d got no grant expected one", d, p);
    end
    @(posedge clk);
    #1;
    if (d == 0) req[p] = 1'b0; else reqb[p] = 1'b0;
  endtask

  initial begin
    int base;
    for (int p = 0; p < 2; p++) begin
      req[p] = 1'b0; we[p] = 1'b0; addr[p] = '0; wdata[p] = '0;
      reqb[p] = 1'b0; web[p] = 1'b0; addrb[p] = '0; wdatab[p] = '0;
    end
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 4'd0; wdata[0] = 8'h11;
    exp_w(0, 0, 0, 8'h11);
    repeat (3) begin
      @(negedge clk);
      chk("reset_outputs", int'({g0, g1, rv0, rv1, busy, mw, ra, din, rd}), 0);
    end
    reset = 1'b1;
    @(negedge clk);
    chk("first_gnt0", int'(g0), 1);
    @(posedge clk);
    #1 req[0] = 1'b0;

    base = mw_cnt;
    exp_w(0, 0, 3, 8'hA5);
    issue(0, 0, 1'b1, 4'd3, 8'hA5);
    exp_r(0, 0, 3, 8'hA5);
    issue(0, 0, 1'b0, 4'd3, 8'h00);
    chk("w_mem_pulses", mw_cnt - base, 1);

    exp_w(0, 1, 15, 8'h3C);
    exp_r(0, 0, 15, 8'h3C);
    fork
      issue(0, 0, 1'b0, 4'd15, 8'h00);
      issue(0, 1, 1'b1, 4'd15, 8'h3C);
    join

    for (int i = 0; i < 4; i++) begin
      exp_w(0, 1, 12 + i, 8'hC0 + i);
      exp_w(0, 0, 8 + i, 8'h80 + i);
    end
    base = cyc;
    fork
      for (int i = 0; i < 4; i++) issue(0, 0, 1'b1, 4'(8 + i), 8'(8'h80 + i));
      for (int j = 0; j < 4; j++) issue(0, 1, 1'b1, 4'(12 + j), 8'(8'hC0 + j));
    join
    chk("rr_burst_cycles", cyc - base, 17);
    exp_r(0, 1, 13, 8'hC1);
    issue(0, 1, 1'b0, 4'd13, 8'h00);
    exp_r(0, 0, 8, 8'h80);
    issue(0, 0, 1'b0, 4'd8, 8'h00);

    exp_w(1, 0, 1, 8'h10);
    exp_w(1, 0, 2, 8'h20);
    exp_w(1, 0, 3, 8'h30);
    exp_w(1, 1, 4, 8'h40);
    fork
      begin
        issue(1, 0, 1'b1, 4'd1, 8'h10);
        issue(1, 0, 1'b1, 4'd2, 8'h20);
        issue(1, 0, 1'b1, 4'd3, 8'h30);
      end
      issue(1, 1, 1'b1, 4'd4, 8'h40);
    join
    chk("prio_gnt1_gap", g1_gap, 2);
    exp_r(1, 1, 4, 8'h40);
    issue(1, 1, 1'b0, 4'd4, 8'h00);

    exp_w(0, 0, 7, 8'h42);
    issue(0, 0, 1'b1, 4'd7, 8'h42);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 4'd7; wdata[0] = 8'hFF;
    @(posedge clk);
    #2;
    chk("mid_access_busy_wmem", int'({busy, mw}), 3);
    reset = 1'b0;
    #1;
    chk("reset_kills_access", int'({g0, g1, rv0, rv1, busy, mw}), 0);
    req[0] = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    exp_r(0, 0, 7, 8'h42);
    issue(0, 0, 1'b0, 4'd7, 8'h00);

    for (int i = 0; i < 20 && (gq0.size() + rq0.size() + gq1.size() + rq1.size()) > 0; i++) @(negedge clk);
    chk("queues_drained", gq0.size() + rq0.size() + gq1.size() + rq1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
